// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory access unit: funct3 encodings,
// FSM state type and access-size / lane-offset decoding.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    LF3_LB  = 3'b000,
    LF3_LH  = 3'b001,
    LF3_LW  = 3'b010,
    LF3_LBU = 3'b100,
    LF3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SF3_SB = 3'b000,
    SF3_SH = 3'b001,
    SF3_SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mau_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  // funct3[1:0] carries the width for both loads and stores; anything
  // that is not a byte or half encoding is handled as a word.
  function automatic acc_size_t size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [1:0] lane_off(input acc_size_t sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return a;
      SZ_HALF: return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input acc_size_t sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      default: return |a;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory access unit (master) and the
// data-cache port (slave).
interface mem_access_unit_if;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Combinational load alignment: picks the byte/half addressed by off out of
// a bus word and sign- or zero-extends it according to funct3.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    // funct3[2] marks the unsigned load variants
    sext = ~funct3[2];
    case (size_of(funct3))
      SZ_BYTE: load_data = {{24{sext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{sext & half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage executor: runs one data-bus transaction per accepted request
// and stalls the pipeline meanwhile. Optional macro: MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              ctrl_read,
  input  logic              ctrl_write,
  input  logic [3:0]        ctrl_wmask,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              bus_err,
  output logic              misalign,
  mem_access_unit_if.master dmem
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES);

  mau_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       off_q, off_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             done_q, done_d;
  logic [31:0]      load_data_q, load_data_d;
  logic             bus_err_q, bus_err_d;
  logic             misalign_q, misalign_d;

  logic             access;
  logic             trap;
  acc_size_t        req_size;
  logic [1:0]       req_off;
  logic [31:0]      store_wdata;
  logic [31:0]      aligned_data;

  always_comb begin
    access   = req_valid & (ctrl_read | ctrl_write);
    req_size = size_of(funct3);
    req_off  = lane_off(req_size, addr[1:0]);
    case (req_size)
      SZ_BYTE: store_wdata = {4{store_data[7:0]}};
      SZ_HALF: store_wdata = {2{store_data[15:0]}};
      default: store_wdata = store_data;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = is_misaligned(req_size, addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  load_align u_load_align (
    .rdata     (dmem.dmem_rdata),
    .off       (off_q),
    .funct3    (funct3_q),
    .load_data (aligned_data)
  );

  assign cnt_inc = (cnt_q == TERM_CNT) ? cnt_q : cnt_q + 1'b1;

  // Result flags are only non-zero in the cycle done is high.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    done_d      = 1'b0;
    load_data_d = '0;
    bus_err_d   = 1'b0;
    misalign_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (trap) begin
            state_d    = DONE;
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d  = BUSY;
            cnt_d    = '0;
            addr_d   = {addr[31:2], 2'b00};
            be_d     = ctrl_write ? (ctrl_wmask << req_off) : 4'b0000;
            wdata_d  = store_wdata;
            rd_d     = ~ctrl_write;
            wr_d     = ctrl_write;
            off_d    = req_off;
            funct3_d = funct3;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_inc;
        // A response in the terminal-count cycle still completes normally.
        if (dmem.dmem_resp) begin
          state_d     = DONE;
          done_d      = 1'b1;
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          load_data_d = rd_q ? aligned_data : 32'h0;
        end else if (cnt_inc == TERM_CNT) begin
          state_d   = DONE;
          done_d    = 1'b1;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          bus_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      funct3_q    <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
      load_data_q <= '0;
      bus_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      done_q      <= done_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
      misalign_q  <= misalign_d;
    end
  end

  // stall is forced low while reset is held so every output reads 0.
  assign stall = rst_n & (((state_q == IDLE) & access) | (state_q == BUSY));

  assign done      = done_q;
  assign load_data = load_data_q;
  assign bus_err   = bus_err_q;
  assign misalign  = misalign_q;

  assign dmem.dmem_address     = addr_q;
  assign dmem.dmem_read        = rd_q;
  assign dmem.dmem_write       = wr_q;
  assign dmem.dmem_byte_enable = be_q;
  assign dmem.dmem_wdata       = wdata_q;

endmodule
